// File: rtl/state_packer.sv
// Packs the serial stream of sampled unit states into WORD_W-bit words and
// buffers them in a first-word-fall-through FIFO for the state-memory writer.
module state_packer #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned NUM_UNITS  = 100,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              state_in,
  input  logic              state_in_en,
  output logic [WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [BIT_W-1:0]  bit_cnt;
  logic [UNIT_W-1:0] unit_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [WORD_W-1:0] pack_q;

  logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow_q;

  logic              cap_c;
  logic              last_c;
  logic              done_c;
  logic              full_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic [WORD_W-1:0] word_c;

  // Capture, completion and FIFO handshake decode.
  always_comb begin
    cap_c  = en & state_in_en;
    last_c = (unit_cnt == UNIT_W'(NUM_UNITS - 1));
    done_c = cap_c & ((bit_cnt == BIT_W'(WORD_W - 1)) | last_c);
    word_c = pack_q;
    word_c[bit_cnt] = state_in;
    full_c = (count == CNT_W'(FIFO_DEPTH));
    pop_c  = (count != '0) & out_ready;
    push_c = done_c & (~full_c | pop_c);
    drop_c = done_c & full_c & ~pop_c;
  end

  // Packing counters; they advance even when a completed word is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      unit_cnt <= '0;
      word_idx <= '0;
      pack_q   <= '0;
    end else if (clr) begin
      bit_cnt  <= '0;
      unit_cnt <= '0;
      word_idx <= '0;
      pack_q   <= '0;
    end else if (cap_c) begin
      if (done_c) begin
        bit_cnt  <= '0;
        pack_q   <= '0;
        unit_cnt <= last_c ? '0 : unit_cnt + UNIT_W'(1);
        word_idx <= last_c ? '0 : word_idx + ADDR_W'(1);
      end else begin
        bit_cnt  <= bit_cnt + BIT_W'(1);
        unit_cnt <= unit_cnt + UNIT_W'(1);
        pack_q   <= word_c;
      end
    end
  end

  // Word FIFO with sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_addr[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push_c) begin
        mem_data[wr_ptr] <= word_c;
        mem_addr[wr_ptr] <= word_idx;
        mem_last[wr_ptr] <= last_c;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count <= count + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count <= count - CNT_W'(1);
      end
      if (drop_c) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign out_data  = mem_data[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];
  assign out_last  = mem_last[rd_ptr];
  assign out_valid = (count != '0);
  assign overflow  = overflow_q;
  assign busy      = (bit_cnt != '0) | (count != '0);

endmodule
